// File: rtl/game_level_fsm.sv
// game_level_fsm: multi-level game sequencer.
// The game waits in START for a start button edge. In PLAY it watches every
// player's x-position against the finish line. When all players finish it
// holds in LEVEL_DONE for a fixed pause and then plays the next level, or it
// moves to FINISH after the last level.
// Optional build macro LEVEL_TIMEOUT_EN adds a per-level time limit. When the
// limit runs out the game moves to GAME_OVER.
// All outputs are registered.

module game_level_fsm #(
  parameter int              NUM_PLAYERS       = 2,
  parameter int              NUM_LEVELS        = 3,
  parameter int              POS_W             = 12,
  parameter int unsigned     FINISH_X          = 700,
  parameter int unsigned     INTERLEVEL_CYCLES = 40_000_000,
  parameter longint unsigned TIMEOUT_CYCLES    = 64'd2_400_000_000
) (
  input  logic                                                  clk_40,
  input  logic                                                  rst_n,
  input  logic                                                  m_left,
  input  logic                                                  gpio,
  input  logic                                                  restart,
  input  logic [NUM_PLAYERS*POS_W-1:0]                          xpos_players,
  output logic [2:0]                                            game_state,
  output logic [((NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1)-1:0] level,
  output logic [NUM_PLAYERS-1:0]                                players_done,
  output logic                                                  level_done_pulse
);

  localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam logic [LVL_W-1:0] LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);

  localparam int IL_W = (INTERLEVEL_CYCLES > 1) ? $clog2(INTERLEVEL_CYCLES) : 1;
  localparam logic [IL_W-1:0] IL_LAST = IL_W'(INTERLEVEL_CYCLES - 1);

  localparam logic [63:0] FINISH_W = 64'(FINISH_X);

`ifdef LEVEL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 64'd1);
`endif

  typedef enum logic [2:0] {
    ST_START      = 3'd0,
    ST_PLAY       = 3'd1,
    ST_LEVEL_DONE = 3'd2,
    ST_FINISH     = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  state_t          state;
  logic [IL_W-1:0] il_cnt;
`ifdef LEVEL_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
`endif

  // Edge history. hist_valid stays low for the first cycle after reset.
  // This stops a button that is held across reset release from reading as a
  // new press.
  logic start_prev;
  logic restart_prev;
  logic hist_valid;
  logic start_in;
  logic start_edge;
  logic restart_edge;
  logic all_done;

  assign start_in     = m_left | gpio;
  assign start_edge   = hist_valid & start_in & ~start_prev;
  assign restart_edge = hist_valid & restart & ~restart_prev;
  assign all_done     = &players_done;
  assign game_state   = state;

  // Per-player finish flags; unsigned compare, inclusive of the finish line
  always_ff @(posedge clk_40 or negedge rst_n) begin
    if (!rst_n) begin
      players_done <= '0;
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        players_done[i] <= (64'(xpos_players[i*POS_W +: POS_W]) >= FINISH_W);
      end
    end
  end

  // Game sequencing; counters fall back to zero unless they keep counting in the same state
  always_ff @(posedge clk_40 or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_START;
      level            <= '0;
      level_done_pulse <= 1'b0;
      il_cnt           <= '0;
`ifdef LEVEL_TIMEOUT_EN
      to_cnt           <= '0;
`endif
      start_prev       <= 1'b0;
      restart_prev     <= 1'b0;
      hist_valid       <= 1'b0;
    end else begin
      start_prev       <= start_in;
      restart_prev     <= restart;
      hist_valid       <= 1'b1;
      level_done_pulse <= 1'b0;
      il_cnt           <= '0;
`ifdef LEVEL_TIMEOUT_EN
      to_cnt           <= '0;
`endif
      case (state)
        ST_START: begin
          if (start_edge) begin
            state <= ST_PLAY;
            level <= '0;
          end
        end
        ST_PLAY: begin
          if (all_done) begin
            level_done_pulse <= 1'b1;
            state <= (level < LAST_LEVEL) ? ST_LEVEL_DONE : ST_FINISH;
          end
`ifdef LEVEL_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state <= ST_GAME_OVER;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        ST_LEVEL_DONE: begin
          if (il_cnt == IL_LAST) begin
            state <= ST_PLAY;
            if (level < LAST_LEVEL) begin
              level <= level + LVL_W'(1);
            end
          end else begin
            il_cnt <= il_cnt + IL_W'(1);
          end
        end
        ST_FINISH, ST_GAME_OVER: begin
          if (restart_edge) begin
            state <= ST_START;
            level <= '0;
          end
        end
        default: begin
          state <= ST_START;
          level <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_level_fsm.sv
// tb_game_level_fsm: directed vector bench for game_level_fsm.
// The bench uses 2 players, 2 levels, a 4-cycle interlevel pause and a 20-cycle timeout.

module tb_game_level_fsm;

  logic        clk_40 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        m_left = 1'b0;
  logic        gpio   = 1'b0;
  logic        restart = 1'b0;
  logic [23:0] xpos_players = '0;
  logic [2:0]  game_state;
  logic [0:0]  level;
  logic [1:0]  players_done;
  logic        level_done_pulse;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        m;
    logic        g;
    logic        r;
    logic [11:0] p0;
    logic [11:0] p1;
    logic [2:0]  st;
    logic        lvl;
    logic [1:0]  done;
    logic        pulse;
  } vec_t;

  vec_t vecs[$];

  game_level_fsm #(
    .NUM_PLAYERS(2),
    .NUM_LEVELS(2),
    .POS_W(12),
    .FINISH_X(700),
    .INTERLEVEL_CYCLES(4),
    .TIMEOUT_CYCLES(64'd20)
  ) dut (
    .clk_40(clk_40),
    .rst_n(rst_n),
    .m_left(m_left),
    .gpio(gpio),
    .restart(restart),
    .xpos_players(xpos_players),
    .game_state(game_state),
    .level(level),
    .players_done(players_done),
    .level_done_pulse(level_done_pulse)
  );

  always #5 clk_40 = ~clk_40;

  function automatic vec_t mk(logic m, logic g, logic r, logic [11:0] a, logic [11:0] b,
                              logic [2:0] s, logic l, logic [1:0] d, logic p);
    vec_t v;
    v.m = m; v.g = g; v.r = r; v.p0 = a; v.p1 = b;
    v.st = s; v.lvl = l; v.done = d; v.pulse = p;
    return v;
  endfunction

  task automatic applyStimulus(input logic m, input logic g, input logic r,
                               input logic [11:0] a, input logic [11:0] b);
    m_left = m;
    gpio = g;
    restart = r;
    xpos_players = {b, a};
    @(posedge clk_40);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] s, input logic l,
                             input logic [1:0] d, input logic p);
    checks++;
    if ({game_state, level, players_done, level_done_pulse} !== {s, l, d, p}) begin
      errors++;
      $display("[TB] FAIL %s: got state=%0d level=%0d done=%b pulse=%b, want state=%0d level=%0d done=%b pulse=%b",
               name, game_state, level, players_done, level_done_pulse, s, l, d, p);
    end
  endtask

  initial begin
    // Reset sequence, start debounce, two levels, finish, restart handling
    vecs.push_back(mk(0,0,0,   0,   0, 0,0,2'b00,0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0,1,0, 0, 0, 1,0,2'b00,0));
    for (int i = 0; i < 2; i++)  vecs.push_back(mk(0,0,0, 0, 0, 1,0,2'b00,0));
    for (int i = 0; i < 5; i++)  vecs.push_back(mk(0,0,0, 700, 699, 1,0,2'b01,0));
    vecs.push_back(mk(0,0,0, 700, 700, 1,0,2'b11,0));
    vecs.push_back(mk(0,0,0,   0,   0, 2,0,2'b00,1));
    vecs.push_back(mk(0,0,0, 800, 800, 2,0,2'b11,0));
    vecs.push_back(mk(0,0,0,   0,   0, 2,0,2'b00,0));
    vecs.push_back(mk(0,0,0,   0,   0, 2,0,2'b00,0));
    vecs.push_back(mk(0,0,0,   0,   0, 1,1,2'b00,0));
    vecs.push_back(mk(0,0,0, 700, 700, 1,1,2'b11,0));
    vecs.push_back(mk(0,0,0, 700, 700, 3,1,2'b11,1));
    vecs.push_back(mk(1,0,0, 700, 700, 3,1,2'b11,0));
    vecs.push_back(mk(0,0,0, 700, 700, 3,1,2'b11,0));
    vecs.push_back(mk(1,0,1,   0,   0, 0,0,2'b00,0));
    vecs.push_back(mk(0,0,1,   0,   0, 0,0,2'b00,0));
    vecs.push_back(mk(0,0,1,   0,   0, 0,0,2'b00,0));
    vecs.push_back(mk(0,0,0,   0,   0, 0,0,2'b00,0));
    vecs.push_back(mk(0,0,1,   0,   0, 0,0,2'b00,0));
    vecs.push_back(mk(1,0,1,   0,   0, 1,0,2'b00,0));
    vecs.push_back(mk(1,0,0,   0,   0, 1,0,2'b00,0));
    vecs.push_back(mk(1,0,1,   0,   0, 1,0,2'b00,0));
    vecs.push_back(mk(1,0,0,   0,   0, 1,0,2'b00,0));

    #3;
    checkOutput("reset_state", 0, 0, 2'b00, 0);
    @(posedge clk_40);
    #1;
    checkOutput("reset_hold", 0, 0, 2'b00, 0);
    #3 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].m, vecs[i].g, vecs[i].r, vecs[i].p0, vecs[i].p1);
      checkOutput($sformatf("vec[%0d]", i), vecs[i].st, vecs[i].lvl, vecs[i].done, vecs[i].pulse);
    end

    // Asynchronous reset in the middle of LEVEL_DONE, with m_left held through release
    applyStimulus(1, 0, 0, 700, 700);
    checkOutput("rst_pre_done", 1, 0, 2'b11, 0);
    applyStimulus(1, 0, 0, 700, 700);
    checkOutput("rst_enter_ld", 2, 0, 2'b11, 1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_async", 0, 0, 2'b00, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_held", 0, 0, 2'b00, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput($sformatf("rst_hold_btn[%0d]", i), 0, 0, 2'b00, 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_btn_low", 0, 0, 2'b00, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_new_edge", 1, 0, 2'b00, 0);

    // Idle PLAY for the full time limit
    for (int i = 0; i < 19; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput($sformatf("idle[%0d]", i), 1, 0, 2'b00, 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
`ifdef LEVEL_TIMEOUT_EN
    checkOutput("timeout", 4, 0, 2'b00, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("gameover_restart", 0, 0, 2'b00, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("to_restart_play", 1, 0, 2'b00, 0);
    for (int i = 0; i < 18; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput($sformatf("to_idle[%0d]", i), 1, 0, 2'b00, 0);
    end
    applyStimulus(0, 0, 0, 700, 700);
    checkOutput("to_done_flags", 1, 0, 2'b11, 0);
    applyStimulus(0, 0, 0, 700, 700);
    checkOutput("to_complete_wins", 2, 0, 2'b11, 1);
`else
    checkOutput("no_timeout", 1, 0, 2'b00, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput($sformatf("no_timeout_more[%0d]", i), 1, 0, 2'b00, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
